// File: rtl/idct_8x8_engine_if.sv
// Coefficient-in / pixel-out stream bundle for the 8x8 IDCT engine.
// The engine takes the slave side; the producer/consumer takes the master side.
interface idct_8x8_engine_if #(
   parameter int COEF_W = 12
);
   logic signed [COEF_W-1:0] in_coef;
   logic                     in_valid;
   logic                     in_ready;
   logic [7:0]               out_pixel;
   logic                     out_valid;
   logic                     out_ready;
   logic                     out_last;

   modport master (
      output in_coef, in_valid, out_ready,
      input  in_ready, out_pixel, out_valid, out_last
   );

   modport slave (
      input  in_coef, in_valid, out_ready,
      output in_ready, out_pixel, out_valid, out_last
   );
endinterface

// File: rtl/idct_8x8_engine.sv
// 8x8 inverse DCT: buffers 64 coefficients, then one 3-stage MAC pass of 64 terms per pixel.
// Latency 67 cycles per pixel (66 compute + emit); input and output never overlap, EMIT holds under backpressure.
module idct_8x8_engine #(
   parameter int COEF_W      = 12,
   parameter int ACC_W       = 32,
   parameter int LEVEL_SHIFT = 128
) (
   input logic              clk,
   input logic              rst_n,
   idct_8x8_engine_if.slave bus
);

   typedef enum logic [1:0] {LOAD, COMPUTE, EMIT} state_t;

   state_t state, state_d;

   logic signed [COEF_W-1:0] coef_buf [64];
   logic [5:0]               cnt;
   logic [5:0]               p;
   logic [6:0]               ccnt;
   logic                     run_q;
   logic                     s1_vld, s2_vld;
   logic signed [COEF_W-1:0] coef_q;
   logic signed [8:0]        ta_q, tb_q;
   logic signed [ACC_W-1:0]  prod_q;
   logic signed [ACC_W-1:0]  acc, acc_sum;
   logic signed [ACC_W:0]    rnd, shf, lvl;
   logic [7:0]               pix_c;
   logic [7:0]               out_pixel_q;
   logic [5:0]               j;
   logic                     in_fire, out_fire;

   // Quarter-wave cosine magnitudes, 128*cos(m*pi/16) for m = 0..8.
   function automatic logic signed [8:0] cos_q(input logic [4:0] m);
      logic signed [8:0] c;
      case (m)
         5'd0:    c = 9'sd128;
         5'd1:    c = 9'sd126;
         5'd2:    c = 9'sd118;
         5'd3:    c = 9'sd106;
         5'd4:    c = 9'sd91;
         5'd5:    c = 9'sd71;
         5'd6:    c = 9'sd49;
         5'd7:    c = 9'sd25;
         default: c = 9'sd0;
      endcase
      return c;
   endfunction

   // T[k][n]: the angle (2n+1)k*pi/16 is folded modulo 2*pi onto 0..pi, then onto 0..pi/2.
   function automatic logic signed [8:0] rom(input logic [2:0] k, input logic [2:0] n);
      logic [4:0]        m, f;
      logic signed [8:0] v;
      m = {1'b0, n, 1'b1} * {2'b00, k};
      f = (m > 5'd16) ? (~m + 5'd1) : m;
      if (k == 3'd0)
         v = 9'sd91;
      else if (f > 5'd8)
         v = -cos_q(5'd16 - f);
      else
         v = cos_q(f);
      return v;
   endfunction

   assign j        = ccnt[5:0];
   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = bus.out_valid && bus.out_ready;

   always_comb begin
      acc_sum = s2_vld ? (acc + prod_q) : acc;
      rnd     = {acc_sum[ACC_W-1], acc_sum} + (ACC_W+1)'(32768);
      shf     = rnd >>> 16;
      lvl     = shf + (ACC_W+1)'(LEVEL_SHIFT);
      if (lvl < 0)
         pix_c = 8'd0;
      else if (lvl > 255)
         pix_c = 8'd255;
      else
         pix_c = lvl[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= LOAD;
      else
         state <= state_d;
   end

   always_comb begin
      state_d       = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.out_pixel = out_pixel_q;
      case (state)
         LOAD: begin
            bus.in_ready = run_q;
            if (in_fire && cnt == 6'd63)
               state_d = COMPUTE;
         end
         COMPUTE: begin
            if (ccnt == 7'd65)
               state_d = EMIT;
         end
         EMIT: begin
            bus.out_valid = 1'b1;
            bus.out_last  = (p == 6'd63);
            if (out_fire)
               state_d = (p == 6'd63) ? LOAD : COMPUTE;
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (state == LOAD && in_fire)
         coef_buf[cnt] <= bus.in_coef;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q       <= 1'b0;
         cnt         <= '0;
         p           <= '0;
         ccnt        <= '0;
         acc         <= '0;
         s1_vld      <= 1'b0;
         s2_vld      <= 1'b0;
         coef_q      <= '0;
         ta_q        <= '0;
         tb_q        <= '0;
         prod_q      <= '0;
         out_pixel_q <= '0;
      end else begin
         run_q <= 1'b1;
         case (state)
            LOAD: begin
               if (in_fire) begin
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'd63) begin
                     p    <= '0;
                     ccnt <= '0;
                     acc  <= '0;
                  end
               end
            end
            COMPUTE: begin
               ccnt   <= ccnt + 7'd1;
               s1_vld <= (ccnt < 7'd64);
               coef_q <= coef_buf[j];
               ta_q   <= rom(j[5:3], p[5:3]);
               tb_q   <= rom(j[2:0], p[2:0]);
               s2_vld <= s1_vld;
               prod_q <= ACC_W'(coef_q) * ACC_W'(ta_q) * ACC_W'(tb_q);
               acc    <= acc_sum;
               if (ccnt == 7'd65)
                  out_pixel_q <= pix_c;
            end
            EMIT: begin
               if (out_fire) begin
                  p    <= p + 6'd1;
                  ccnt <= '0;
                  acc  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_idct_8x8_engine.sv
// Bench for idct_8x8_engine: directed and random blocks against a floating-point cosine reference,
// with latency, backpressure, input-blocking and mid-block reset checks.
module tb_idct_8x8_engine;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   idct_8x8_engine_if #(.COEF_W(12)) bus ();

   idct_8x8_engine #(.COEF_W(12), .ACC_W(32), .LEVEL_SHIFT(128)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   int tab [8][8];
   int x [64];
   int exp_px [64];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, expv);
      end
   endtask

   task automatic build_table();
      real c;
      for (int k = 0; k < 8; k++)
         for (int n = 0; n < 8; n++) begin
            c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            tab[k][n] = int'($floor(256.0 * c / 2.0 * $cos((2 * n + 1) * k * 3.14159265358979 / 16.0) + 0.5));
         end
   endtask

   // Direct 2-D inverse transform sum, then round, level shift and clamp.
   task automatic model();
      longint acc, r, v;
      for (int pi = 0; pi < 64; pi++) begin
         acc = 0;
         for (int k = 0; k < 64; k++)
            acc += longint'(x[k]) * tab[k / 8][pi / 8] * tab[k % 8][pi % 8];
         r = (acc + 32768) >>> 16;
         v = r + 128;
         exp_px[pi] = (v < 0) ? 0 : (v > 255) ? 255 : int'(v);
      end
   endtask

   task automatic send_block(input string tag);
      int w;
      for (int i = 0; i < 64; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
         end
         bus.in_valid = 1'b1;
         bus.in_coef  = 12'(x[i]);
         w = 0;
         while (!bus.in_ready && w < 500) begin
            @(posedge clk); #1;
            w++;
         end
         if (w >= 500) begin
            check({tag, " in_ready timeout"}, 32'(w), 32'd0);
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic recv_block(input string tag, input int stall_px, input bit toggle, input int stop_px);
      int lat;
      bit rdy_seen;
      rdy_seen = 1'b0;
      for (int i = 0; i < stop_px; i++) begin
         lat = 0;
         while (!bus.out_valid && lat < 300) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            if (toggle) begin
               bus.in_valid = 1'($urandom);
               bus.in_coef  = 12'($urandom);
            end
            @(posedge clk); #1;
            lat++;
         end
         bus.in_valid = 1'b0;
         check($sformatf("%s px%0d latency", tag, i), 32'(lat), 32'd66);
         if (lat >= 300) return;
         check($sformatf("%s px%0d value", tag, i), 32'(bus.out_pixel), 32'(exp_px[i]));
         check($sformatf("%s px%0d last", tag, i), 32'(bus.out_last), 32'(i == 63));
         if (i == stall_px) begin
            bus.out_ready = 1'b0;
            repeat (10) begin
               @(posedge clk); #1;
               check($sformatf("%s stall value", tag), 32'(bus.out_pixel), 32'(exp_px[i]));
               check($sformatf("%s stall valid", tag), 32'(bus.out_valid), 32'd1);
               check($sformatf("%s stall in_ready", tag), 32'(bus.in_ready), 32'd0);
            end
            bus.out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      check({tag, " in_ready low while busy"}, 32'(rdy_seen), 32'd0);
   endtask

   task automatic do_block(input string tag, input int stall_px, input bit toggle, input int stop_px);
      model();
      send_block(tag);
      recv_block(tag, stall_px, toggle, stop_px);
      if (stop_px == 64) begin
         check({tag, " no extra pixel"}, 32'(bus.out_valid), 32'd0);
         check({tag, " ready for next block"}, 32'(bus.in_ready), 32'd1);
      end
   endtask

   task automatic fill(input int dc, input int idx, input int val);
      for (int i = 0; i < 64; i++) x[i] = 0;
      x[0]   = dc;
      x[idx] = x[idx] + val;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 64; i++)
         x[i] = (i == 0) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 400)) - 200;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_coef   = '0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      build_table();

      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", 32'(bus.in_ready), 32'd0);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset out_last", 32'(bus.out_last), 32'd0);
      check("reset out_pixel", 32'(bus.out_pixel), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready after release", 32'(bus.in_ready), 32'd1);

      fill(0, 0, 0);
      do_block("zeros", -1, 1'b0, 64);
      fill(64, 0, 0);
      do_block("dc64", -1, 1'b0, 64);
      fill(0, 1, 100);
      do_block("x01_100", -1, 1'b0, 64);
      fill(2047, 0, 0);
      do_block("clamp_hi", -1, 1'b0, 64);
      fill(-2048, 0, 0);
      do_block("clamp_lo", -1, 1'b0, 64);
      fill_random();
      do_block("rand_stall", 5, 1'b1, 64);
      fill_random();
      do_block("rand", -1, 1'b0, 64);

      // Abort a block partway through pixel 20's accumulation.
      fill_random();
      do_block("abort", -1, 1'b0, 20);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort out_valid", 32'(bus.out_valid), 32'd0);
      check("abort out_last", 32'(bus.out_last), 32'd0);
      check("abort out_pixel", 32'(bus.out_pixel), 32'd0);
      check("abort in_ready", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort in_ready after release", 32'(bus.in_ready), 32'd1);
      check("abort no stale pixel", 32'(bus.out_valid), 32'd0);

      fill(64, 0, 0);
      do_block("fresh_dc64", -1, 1'b0, 64);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
